// File: rtl/conv_coeff_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_coeff_sched
// Purpose  : Shadow/active 3x3 kernel bank with vsync-safe swap and serial
//            coefficient streaming. Optional preset ROM under CONV_PRESET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_coeff_sched #(
    parameter int COEFF_W = 9,
    parameter int N_COEFF = 9,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs_i,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_addr_i,
    input  logic [COEFF_W-1:0] wr_data_i,
    input  logic               commit_i,
    input  logic [1:0]         preset_sel_i,
    input  logic               preset_ld_i,
    output logic [COEFF_W-1:0] coeff_o,
    output logic               pending_o,
    output logic               applied_o,
    output logic               short_vs_o,
    output logic               busy_o
);

    localparam logic [IDX_W-1:0] C_N    = IDX_W'(N_COEFF);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_COEFF - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pending_q, pending_d;
    logic               fresh_q, fresh_d;
    logic               applied_q, applied_d;
    logic               short_q, short_d;
    logic               w_swap;

    logic [COEFF_W-1:0] shadow_q [N_COEFF];
    logic [COEFF_W-1:0] active_q [N_COEFF];

`ifdef CONV_PRESET_EN
    function automatic logic [COEFF_W-1:0] preset_val(input logic [1:0] sel, input int i);
        int v;
        case (sel)
            2'd0:    v = (i == 4) ? 1 : 0;
            2'd1:    v = 1;
            2'd2:    v = (i == 4) ? 5 : ((i % 2) == 1 ? -1 : 0);
            default: v = (i == 4) ? 8 : -1;
        endcase
        return COEFF_W'(v);
    endfunction
`else
    logic w_unused_preset;
    assign w_unused_preset = ^{preset_sel_i, preset_ld_i};
`endif

    // Swap only while fully idle so a kernel is never changed mid-frame.
    assign w_swap = pending_q && !vs_i && (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fresh_d   = fresh_q;
        applied_d = 1'b0;
        short_d   = short_q;
        pending_d = commit_i | (pending_q & ~w_swap);
        if (w_swap) begin
            fresh_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (vs_i) begin
                    state_d = S_STREAM;
                    idx_d   = IDX_W'(1);
                end
            end
            S_STREAM: begin
                if (!vs_i) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    short_d = 1'b1;
                end else if (idx_q == C_LAST) begin
                    state_d = S_HOLD;
                    idx_d   = C_N;
                    if (fresh_q) begin
                        applied_d = 1'b1;
                        fresh_d   = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_HOLD: begin
                idx_d = C_N;
                if (!vs_i) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            fresh_q   <= 1'b0;
            applied_q <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            fresh_q   <= fresh_d;
            applied_q <= applied_d;
            short_q   <= short_d;
        end
    end

    // Active copies the pre-write shadow on a swap edge (NBA ordering).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_COEFF; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (w_swap) begin
                for (int i = 0; i < N_COEFF; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
`ifdef CONV_PRESET_EN
            if (preset_ld_i) begin
                for (int i = 0; i < N_COEFF; i++) begin
                    shadow_q[i] <= preset_val(preset_sel_i, i);
                end
            end else
`endif
            if (wr_en_i && (wr_addr_i < C_N)) begin
                shadow_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign coeff_o    = (idx_q < C_N) ? active_q[idx_q] : '0;
    assign pending_o  = pending_q;
    assign applied_o  = applied_q;
    assign short_vs_o = short_q;
    assign busy_o     = (state_q == S_STREAM);

endmodule
`default_nettype wire
